// File: rtl/md5_cracker_pkg.sv
// Shared definitions for the MD5 cracking controller: character bounds,
// the candidate generator state type and a candidate-width helper.
package md5_cracker_pkg;

  localparam logic [7:0] CHAR_MIN = 8'h61;
  localparam logic [7:0] CHAR_MAX = 8'h7a;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  function automatic int unsigned cand_width(input int unsigned max_len);
    return 8 * max_len;
  endfunction

endpackage

// File: rtl/candidate_digit.sv
// One odometer digit: steps by a fixed stride on carry_in and reloads its
// start value (raising carry_out) when the step would pass CHAR_MAX.
module candidate_digit #(
  parameter logic [7:0] CHAR_MAX = md5_cracker_pkg::CHAR_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       load_active,
  input  logic       enable,
  input  logic [7:0] start_value,
  input  logic [2:0] step,
  input  logic       carry_in,
  output logic [7:0] value,
  output logic       carry_out
);

  logic [8:0] sum;
  logic       wrap;

  // 9-bit sum so a stride near the top of the range cannot wrap back into it
  always_comb begin
    sum       = {1'b0, value} + {6'b0, step};
    wrap      = sum > {1'b0, CHAR_MAX};
    carry_out = carry_in && wrap;
  end

  // Inactive digits sit at zero so the concatenated candidate is already padded
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_active ? start_value : '0;
    end else if (carry_in && enable) begin
      value <= wrap ? start_value : sum[7:0];
    end
  end

endmodule

// File: rtl/password_candidate_gen.sv
// Enumerates lowercase plaintext candidates as a strided odometer and
// presents them one per cycle over a valid/ready handshake.
module password_candidate_gen #(
  parameter int unsigned MAX_LEN  = 5,
  parameter logic [7:0]  CHAR_MIN = md5_cracker_pkg::CHAR_MIN,
  parameter logic [7:0]  CHAR_MAX = md5_cracker_pkg::CHAR_MAX
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              stop,
  input  logic [2:0]                                        increment,
  input  logic [7:0]                                        starting_position,
  output logic                                              cand_valid,
  input  logic                                              cand_ready,
  output logic [md5_cracker_pkg::cand_width(MAX_LEN)-1:0]   candidate,
  output logic [3:0]                                        cand_length,
  output logic                                              busy,
  output logic                                              done,
  output logic [31:0]                                       count
);

  import md5_cracker_pkg::*;

  state_t               state;
  logic [7:0]           start_char;
  logic [2:0]           step0;
  logic [7:0]           start_sel;
  logic                 fire;
  logic                 advance;
  logic                 accept;
  logic                 overflow;
  logic                 grow;
  logic                 finish;
  logic [MAX_LEN:0]     carry;
  logic [MAX_LEN-1:0]   digit_active;
  logic [MAX_LEN-1:0]   load_active;

  always_comb begin
    fire      = cand_valid && cand_ready;
    advance   = fire && !stop;
    accept    = start && !stop && ((state == IDLE) || (state == DONE));
    start_sel = ((starting_position < CHAR_MIN) || (starting_position > CHAR_MAX))
                ? CHAR_MIN : starting_position;
    overflow  = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i + 1 == 32'(cand_length)) overflow = carry[i+1];
      digit_active[i] = i < 32'(cand_length);
      load_active[i]  = accept ? (i == 0) : (i <= 32'(cand_length));
    end
    grow   = advance && overflow && (32'(cand_length) < MAX_LEN);
    finish = advance && overflow && (32'(cand_length) == MAX_LEN);
  end

  assign carry[0] = advance;

  // Carry into a digit beyond the current length is masked, so the carry out
  // of the last active digit is the length roll-over condition.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_digit
    logic [7:0] digit_start;
    logic [2:0] digit_step;

    if (g == 0) begin : g_lead
      assign digit_start = accept ? start_sel : start_char;
      assign digit_step  = step0;
    end else begin : g_rest
      assign digit_start = CHAR_MIN;
      assign digit_step  = 3'd1;
    end

    candidate_digit #(
      .CHAR_MAX(CHAR_MAX)
    ) u_digit (
      .clk         (clk),
      .reset       (reset),
      .load        (accept || grow),
      .load_active (load_active[g]),
      .enable      (!finish),
      .start_value (digit_start),
      .step        (digit_step),
      .carry_in    (carry[g] && digit_active[g]),
      .value       (candidate[8*g +: 8]),
      .carry_out   (carry[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cand_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      cand_length <= '0;
      start_char  <= '0;
      step0       <= '0;
    end else if (stop) begin
      state      <= IDLE;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      if (fire && (count != '1)) count <= count + 32'd1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            start_char  <= start_sel;
            step0       <= (increment == 3'd0) ? 3'd1 : increment;
            cand_length <= 4'd1;
            count       <= '0;
            state       <= EMIT;
            cand_valid  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        EMIT: begin
          if (fire) begin
            if (count != '1) count <= count + 32'd1;
            if (overflow) begin
              if (32'(cand_length) == MAX_LEN) begin
                state      <= DONE;
                cand_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                cand_length <= cand_length + 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_password_candidate_gen.sv
// Self-checking bench for password_candidate_gen (MAX_LEN = 3): hand-written
// corner sequences plus a table of configurations checked against an index model.
module tb_password_candidate_gen;

  localparam int unsigned MAX_LEN = 3;

  logic        clk = 1'b0;
  logic        reset, start, stop, cand_ready;
  logic [2:0]  increment;
  logic [7:0]  starting_position;
  logic        cand_valid, busy, done;
  logic [23:0] candidate;
  logic [3:0]  cand_length;
  logic [31:0] count;

  int checks = 0;
  int errors = 0;

  password_candidate_gen #(.MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .increment         (increment),
    .starting_position (starting_position),
    .cand_valid        (cand_valid),
    .cand_ready        (cand_ready),
    .candidate         (candidate),
    .cand_length       (cand_length),
    .busy              (busy),
    .done              (done),
    .count             (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  incr;
    logic [7:0]  pos;
    logic [7:0]  exp_first;
    int unsigned exp_total;
    int unsigned ready_pct;
  } cfg_t;

  function automatic logic [63:0] pk(input logic v, input logic b, input logic d,
                                     input logic [3:0] len, input logic [23:0] cand,
                                     input logic [31:0] cnt);
    return {1'b0, v, b, d, len, cand, cnt};
  endfunction

  function automatic logic [63:0] outs();
    return pk(cand_valid, busy, done, cand_length, candidate, count);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: candidates listed by handshake index, shortest length first,
  // char 0 as the fastest-moving strided digit, the rest base-26.
  function automatic int unsigned space_size(input int unsigned s, input int unsigned inc);
    int unsigned r, total;
    r = (122 - s) / inc + 1;
    total = 0;
    for (int unsigned l = 0; l < MAX_LEN; l++) begin
      total += r;
      r *= 26;
    end
    return total;
  endfunction

  task automatic model_cand(input int unsigned s, input int unsigned inc, input int unsigned n,
                            output logic [23:0] cand, output logic [3:0] len);
    int unsigned r0, r, k;
    r0  = (122 - s) / inc + 1;
    r   = r0;
    k   = n;
    len = 4'd1;
    while (k >= r) begin
      k -= r;
      r *= 26;
      len++;
    end
    cand = '0;
    cand[7:0] = 8'(s + inc * (k % r0));
    k = k / r0;
    for (int j = 1; j < int'(len); j++) begin
      cand[8*j +: 8] = 8'(97 + k % 26);
      k = k / 26;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [2:0] inc, input logic [7:0] pos);
    increment = inc;
    starting_position = pos;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cfg(input cfg_t c);
    int unsigned s, inc, total, n, cyc, budget, run_err;
    logic [23:0] ecand;
    logic [3:0]  elen;
    logic        fin;
    s      = ((c.pos < 8'h61) || (c.pos > 8'h7a)) ? 32'd97 : 32'(c.pos);
    inc    = (c.incr == 3'd0) ? 32'd1 : 32'(c.incr);
    total  = space_size(s, inc);
    budget = c.exp_total * 3 + 50;
    n = 0; cyc = 0; run_err = 0; fin = 1'b0;
    cand_ready = 1'b0;
    pulse_start(c.incr, c.pos);
    check("first_char", 64'(candidate[7:0]), 64'(c.exp_first));
    while (!fin && cyc < budget) begin
      if (n < total) begin
        model_cand(s, inc, n, ecand, elen);
        checks++;
        if (outs() !== pk(1'b1, 1'b1, 1'b0, elen, ecand, n)) begin
          errors++; run_err++;
          $display("FAIL stream n=%0d: got %h expected %h", n, outs(),
                   pk(1'b1, 1'b1, 1'b0, elen, ecand, n));
        end
        if (run_err > 10) fin = 1'b1;
      end else begin
        check("done_state", {cand_valid, busy, done, count}, {1'b0, 1'b0, 1'b1, 32'(total)});
        fin = 1'b1;
      end
      if (!fin) begin
        cand_ready = ($urandom_range(99) < c.ready_pct);
        if (cand_ready) n++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("cycle_budget", 64'(cyc), 64'(budget) + 1);
    check("final_count", 64'(count), 64'(c.exp_total));
    if (c.ready_pct == 100) check("no_bubbles", 64'(cyc), 64'(c.exp_total));
    cand_ready = 1'b0;
  endtask

  cfg_t cfgs[6];

  initial begin
    cfgs[0] = '{3'd1, 8'h61, 8'h61, 18278, 100};
    cfgs[1] = '{3'd3, 8'h63, 8'h63, 5624, 100};
    cfgs[2] = '{3'd0, 8'h41, 8'h61, 18278, 85};
    cfgs[3] = '{3'd7, 8'h7a, 8'h7a, 703, 70};
    cfgs[4] = '{3'd4, 8'h61, 8'h61, 4921, 85};
    cfgs[5] = '{3'd6, 8'h7b, 8'h61, 3515, 85};

    reset = 1'b1; start = 1'b0; stop = 1'b0; cand_ready = 1'b0;
    increment = 3'd0; starting_position = 8'h00;
    cycles(2);
    check("reset_state", outs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 32'd0));
    reset = 1'b0;
    @(negedge clk);

    // a/1 stream with backpressure on "q"
    cand_ready = 1'b1;
    pulse_start(3'd1, 8'h61);
    check("first_a", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000061, 32'd0));
    cycles(16);
    cand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_q", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000071, 32'd16));
    end
    cand_ready = 1'b1;
    @(negedge clk);
    check("after_stall_r", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000072, 32'd17));
    cycles(9);
    check("rollover_aa", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006161, 32'd26));
    @(negedge clk);
    check("next_ba", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006162, 32'd27));
    pulse_start(3'd5, 8'h6d);
    check("start_in_emit", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006163, 32'd28));
    cycles(24);
    check("reach_ab", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006261, 32'd52));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_ab", outs(), pk(1'b0, 1'b0, 1'b0, 4'd2, 24'h006261, 32'd53));
    cycles(2);
    check("idle_hold", outs(), pk(1'b0, 1'b0, 1'b0, 4'd2, 24'h006261, 32'd53));

    cand_ready = 1'b0;
    pulse_start(3'd1, 8'h61);
    check("restart", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000061, 32'd0));
    cand_ready = 1'b1;
    cycles(3);
    check("restart_d", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000064, 32'd3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_emit", outs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 32'd0));

    // c/3: "xa" carries into "cb"
    pulse_start(3'd3, 8'h63);
    check("first_c", outs(), pk(1'b1, 1'b1, 1'b0, 4'd1, 24'h000063, 32'd0));
    cycles(15);
    check("reach_xa", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006178, 32'd15));
    @(negedge clk);
    check("xa_to_cb", outs(), pk(1'b1, 1'b1, 1'b0, 4'd2, 24'h006263, 32'd16));
    cand_ready = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_no_hs", {cand_valid, busy, done, count}, {1'b0, 1'b0, 1'b0, 32'd16});

    for (int i = 0; i < 6; i++) run_cfg(cfgs[i]);

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_clears_done", {cand_valid, busy, done}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
